// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one functional-unit result per cycle in
// round-robin order and drives a registered broadcast to the CDB consumers.
// Requester index 0=mem, 1=add, 2=mul, 3=div.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic [N_REQ-1:0]        req_grant,
  output logic                    cdb_valid,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic                    tag_error,
  output logic [15:0]             bcast_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [DATA_W-1:0] r_cdb_data;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic              r_tag_error;
  logic [15:0]       r_bcast_count;

  logic [N_REQ-1:0]  w_grant;
  logic              w_found;
  logic [PTR_W-1:0]  w_gidx;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [DATA_W-1:0] w_sel_data;
  logic [TAG_W-1:0]  w_sel_tag;

  // Round-robin search from r_rr_ptr upward; first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    if (!reset && en) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
        if (!w_found && req_valid[w_idx]) begin
          w_found = 1'b1;
          w_gidx  = w_idx;
        end
      end
    end
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  // Select the granted requester's result and compute the wrapped next pointer.
  always_comb begin
    w_sel_data = req_data[int'(w_gidx)*DATA_W +: DATA_W];
    w_sel_tag  = req_tag[int'(w_gidx)*TAG_W +: TAG_W];
    w_next_ptr = (int'(w_gidx) == N_REQ - 1) ? '0 : w_gidx + 1'b1;
  end

  // Registered broadcast, pointer advance, broadcast counter and sticky tag check.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_cdb_valid   <= 1'b0;
      r_cdb_data    <= '0;
      r_cdb_tag     <= '0;
      r_rr_ptr      <= '0;
      r_tag_error   <= 1'b0;
      r_bcast_count <= '0;
    end else if (en) begin
      if (w_found) begin
        r_cdb_valid   <= 1'b1;
        r_cdb_data    <= w_sel_data;
        r_cdb_tag     <= w_sel_tag;
        r_rr_ptr      <= w_next_ptr;
        r_bcast_count <= r_bcast_count + 16'd1;
        if (!w_sel_tag[TAG_W-1]) begin
          r_tag_error <= 1'b1;
        end
      end else begin
        r_cdb_valid <= 1'b0;
        r_cdb_data  <= '0;
        r_cdb_tag   <= '0;
      end
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign req_grant   = w_grant;
  assign cdb_valid   = r_cdb_valid;
  assign cdb_data    = r_cdb_data;
  assign cdb_tag     = r_cdb_tag;
  assign tag_error   = r_tag_error;
  assign bcast_count = r_bcast_count;

endmodule
